// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: samples a multiplexed active-low 4-digit 7-segment bus, filters each digit for stability, decodes to hex.
// Define SEG_DP_CAPTURE_EN to add the dp port and ignore bit 7 when judging legality.
module seg_scan_decoder #(
  parameter int STABLE_CNT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  an,
  input  logic [7:0]  seg_data,
`ifdef SEG_DP_CAPTURE_EN
  output logic [3:0]  dp,
`endif
  output logic [15:0] value,
  output logic [3:0]  digit_valid,
  output logic        update,
  output logic        pat_err,
  output logic [1:0]  err_digit
);
  localparam logic [7:0] SAT = 8'(STABLE_CNT);
  logic [3:0] an_m, an_s;
  logic [7:0] seg_m, p;
  logic [7:0] lp [4];
  logic [7:0] cnt [4];
  logic       qual, same, acc, legal, ok, chg;
  logic [1:0] idx;
  logic [3:0] nib, old;
  logic [7:0] cur, nxt;

  function automatic logic [4:0] dec(input logic [6:0] s);
    case (s)
      7'h01: dec = 5'h10;
      7'h4F: dec = 5'h11;
      7'h12: dec = 5'h12;
      7'h06: dec = 5'h13;
      7'h4C: dec = 5'h14;
      7'h24: dec = 5'h15;
      7'h20: dec = 5'h16;
      7'h0F: dec = 5'h17;
      7'h00: dec = 5'h18;
      7'h04: dec = 5'h19;
      7'h08: dec = 5'h1A;
      7'h60: dec = 5'h1B;
      7'h31: dec = 5'h1C;
      7'h42: dec = 5'h1D;
      7'h30: dec = 5'h1E;
      7'h38: dec = 5'h1F;
      default: dec = 5'h00;
    endcase
  endfunction

  // a pattern change on a saturated digit must still count as an accept when STABLE_CNT is 1
  always_comb begin
    qual = an_s == 4'b1110 || an_s == 4'b1101 || an_s == 4'b1011 || an_s == 4'b0111;
    idx = !an_s[0] ? 2'd0 : !an_s[1] ? 2'd1 : !an_s[2] ? 2'd2 : 2'd3;
    cur = cnt[idx];
    same = p == lp[idx];
    nxt = !same ? 8'd1 : cur == SAT ? cur : cur + 8'd1;
    acc = qual && nxt == SAT && (cur != SAT || !same);
    {legal, nib} = dec(p[6:0]);
    old = value[{idx, 2'b00} +: 4];
`ifdef SEG_DP_CAPTURE_EN
    ok = legal;
    chg = nib != old || !digit_valid[idx] || dp[idx] != ~p[7];
`else
    ok = legal && p[7];
    chg = nib != old || !digit_valid[idx];
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_m <= '1;
      an_s <= '1;
      seg_m <= '1;
      p <= '1;
      value <= '0;
      digit_valid <= '0;
      update <= 1'b0;
      pat_err <= 1'b0;
      err_digit <= '0;
      for (int i = 0; i < 4; i++) begin
        lp[i] <= '1;
        cnt[i] <= '0;
      end
`ifdef SEG_DP_CAPTURE_EN
      dp <= '0;
`endif
    end else begin
      an_m <= an;
      an_s <= an_m;
      seg_m <= seg_data;
      p <= seg_m;
      update <= acc && ok && chg;
      pat_err <= acc && !ok;
      if (qual) begin
        lp[idx] <= p;
        cnt[idx] <= nxt;
      end
      if (acc && ok) begin
        value[{idx, 2'b00} +: 4] <= nib;
        digit_valid[idx] <= 1'b1;
`ifdef SEG_DP_CAPTURE_EN
        dp[idx] <= ~p[7];
`endif
      end
      if (acc && !ok) begin
        digit_valid[idx] <= 1'b0;
        err_digit <= idx;
      end
    end
  end
endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb_seg_scan_decoder: directed checks of stability filtering, decoding, error reporting and reset.
module tb_seg_scan_decoder;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  an = 4'hF;
  logic [7:0]  seg_data = 8'hFF;
  logic [15:0] value;
  logic [3:0]  digit_valid;
  logic        update, pat_err;
  logic [1:0]  err_digit;
`ifdef SEG_DP_CAPTURE_EN
  logic [3:0]  dp;
`endif
  int total = 0, bad = 0;
  int upd_cnt = 0, err_cnt = 0, both = 0;
  int u0, e0;

  seg_scan_decoder #(.STABLE_CNT(4)) dut (
    .clk(clk), .rst_n(rst_n), .an(an), .seg_data(seg_data),
`ifdef SEG_DP_CAPTURE_EN
    .dp(dp),
`endif
    .value(value), .digit_valid(digit_valid), .update(update),
    .pat_err(pat_err), .err_digit(err_digit)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (update) upd_cnt++;
    if (pat_err) err_cnt++;
    if (update && pat_err) both++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic scan(input logic [3:0] a, input logic [7:0] s, input int n);
    an = a;
    seg_data = s;
    repeat (n) tick();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    repeat (3) tick();
    check("rst_value", value, 0);
    check("rst_valid", digit_valid, 0);
    check("rst_update", update, 0);
    check("rst_pat_err", pat_err, 0);
    check("rst_err_digit", err_digit, 0);
    rst_n = 1'b1;

    u0 = upd_cnt;
    an = 4'b1110;
    seg_data = 8'hA4;
    repeat (5) tick();
    check("lat_early_valid", digit_valid, 4'b0000);
    check("lat_early_update", update, 0);
    tick();
    check("lat_value", value[3:0], 5);
    check("lat_valid", digit_valid, 4'b0001);
    check("lat_update", update, 1);
    tick();
    check("lat_update_drop", update, 0);
    repeat (10) tick();
    check("lat_update_count", upd_cnt - u0, 1);

    u0 = upd_cnt;
    scan(4'b0111, 8'h88, 8);
    scan(4'b1011, 8'hE0, 8);
    scan(4'b1101, 8'hB1, 8);
    scan(4'b1110, 8'hC2, 8);
    check("rr_value", value, 16'hABCD);
    check("rr_valid", digit_valid, 4'hF);
    check("rr_updates", upd_cnt - u0, 4);

    u0 = upd_cnt;
    e0 = err_cnt;
    repeat (4) begin
      scan(4'b1011, 8'h92, 2);
      scan(4'b1011, 8'h86, 2);
    end
    scan(4'b1111, 8'hFF, 4);
    check("alt_value", value[11:8], 4'hB);
    check("alt_updates", upd_cnt - u0, 0);
    check("alt_errs", err_cnt - e0, 0);

    u0 = upd_cnt;
    scan(4'b1101, 8'h86, 8);
    check("d1_value", value[7:4], 3);
    check("d1_updates", upd_cnt - u0, 1);
    u0 = upd_cnt;
    e0 = err_cnt;
    scan(4'b1101, 8'hFF, 8);
    check("ill_errs", err_cnt - e0, 1);
    check("ill_err_digit", err_digit, 1);
    check("ill_valid", digit_valid, 4'b1101);
    check("ill_value", value[7:4], 3);
    check("ill_updates", upd_cnt - u0, 0);

    u0 = upd_cnt;
    e0 = err_cnt;
    scan(4'b1100, 8'h81, 20);
    scan(4'b1111, 8'h81, 20);
    check("noq_value", value, 16'hAB3D);
    check("noq_valid", digit_valid, 4'b1101);
    check("noq_updates", upd_cnt - u0, 0);
    check("noq_errs", err_cnt - e0, 0);
    scan(4'b1110, 8'hC2, 8);
    check("noq_sat_updates", upd_cnt - u0, 0);

    u0 = upd_cnt;
    e0 = err_cnt;
    scan(4'b1110, 8'h04, 8);
`ifdef SEG_DP_CAPTURE_EN
    check("dp_value", value[3:0], 9);
    check("dp_bit", dp[0], 1);
    check("dp_valid", digit_valid[0], 1);
    check("dp_updates", upd_cnt - u0, 1);
`else
    check("nodp_errs", err_cnt - e0, 1);
    check("nodp_err_digit", err_digit, 0);
    check("nodp_valid", digit_valid[0], 0);
    check("nodp_value", value[3:0], 4'hD);
`endif

    scan(4'b1110, 8'h81, 3);
    rst_n = 1'b0;
    #1;
    check("mid_rst_value", value, 0);
    check("mid_rst_valid", digit_valid, 0);
    check("mid_rst_err_digit", err_digit, 0);
    tick();
    tick();
    rst_n = 1'b1;
    repeat (5) tick();
    check("restart_early", digit_valid, 0);
    tick();
    check("restart_valid", digit_valid, 4'b0001);
    check("restart_update", update, 1);
    check("restart_value", value, 0);

    check("never_both", both, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
